// File: rtl/div8u4_seq.sv
// Sequential restoring divider: DVD_W-bit dividend by DVS_W-bit divisor, BPC quotient bits per cycle.
// valid/ready on both sides; the result registers hold the last answer until the next one lands.
module div8u4_seq #(
  parameter int DVD_W = 8,
  parameter int DVS_W = 4,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             ovf,
  output logic             dbz,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid must be held until that edge, and ready never depends on valid.
  localparam int ITERS = DVD_W / BPC;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DVD_W-1:0] work_q, work_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [DVD_W-1:0] quo_q, quo_d;
  logic [DVS_W-1:0] remo_q, remo_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

  // work holds unconsumed dividend bits at the top and fresh quotient bits at the bottom.
  logic [DVS_W:0]   p;
  logic [DVD_W-1:0] w;

  always_comb begin
    p = {1'b0, rem_q};
    w = work_q;
    for (int b = 0; b < BPC; b++) begin
      p = {p[DVS_W-1:0], w[DVD_W-1]};
      w = {w[DVD_W-2:0], 1'b0};
      if (p >= {1'b0, dvs_q}) begin
        p    = p - {1'b0, dvs_q};
        w[0] = 1'b1;
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign quotient  = quo_q;
  assign remainder = remo_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          if (divisor == '0) begin
            quo_d   = '1;
            remo_d  = dividend[DVS_W-1:0];
            ovf_d   = 1'b0;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            work_d  = dividend;
            dvs_d   = divisor;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        work_d = w;
        rem_d  = p[DVS_W-1:0];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          quo_d   = w;
          remo_d  = p[DVS_W-1:0];
          ovf_d   = |w[DVD_W-1:DVS_W];
          dbz_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule
